pc_sequencer: RTL and testbench

Multi-cycle controller that sequences the 32-bit program counter register. It drives the PC's write enable and next-value inputs and tracks the PC's current output. It runs one fetch/execute/update cycle per instruction and arbitrates the candidate next-PC sources: sequential, branch, jump and, optionally, trap. It sits between instruction-memory fetch handshaking, the execute stage and the PC register.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 98 +++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - pc_sequencer handshake/bus bundle: fetch, execute, PC register and status signals
interface pc_sequencer_if;
  logic        start;
  logic        halt;
  logic [31:0] pc_current;
  logic        imem_req;
  logic        imem_ack;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        busy;
  logic [31:0] epc;
  logic [31:0] retired;

  modport master (
    input  start, halt, pc_current, imem_ack, exec_done,
           branch_taken, branch_target, jump, jump_target, exc,
    output imem_req, pc_write, pc_next, busy, epc, retired
  );

  modport slave (
    output start, halt, pc_current, imem_ack, exec_done,
           branch_taken, branch_target, jump, jump_target, exc,
    input  imem_req, pc_write, pc_next, busy, epc, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute/update sequencer for the 32-bit PC register
// Optional trap redirect (exc and misaligned targets) enabled by PC_SEQUENCER_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] PC_INC       = 32'd4
) (
  input  logic           clk,
  input  logic           rst_n_a,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_next;
  logic [31:0] r_retired;
  logic [31:0] w_seq_pc;
  logic [31:0] w_tgt;
  logic        w_redirect;
  logic [31:0] w_sel_pc;

  assign w_seq_pc   = bus.pc_current + PC_INC;
  assign w_redirect = bus.jump | bus.branch_taken;
  assign w_tgt      = bus.jump ? bus.jump_target : bus.branch_target;

`ifdef PC_SEQUENCER_TRAP_EN
  logic [31:0] r_epc;
  logic        w_take_trap;

  // A misaligned redirect is treated as an exception rather than silently masked.
  assign w_take_trap = bus.exc | (w_redirect && (w_tgt[1:0] != 2'b00));
  assign w_sel_pc    = w_take_trap ? TRAP_VECTOR : (w_redirect ? w_tgt : w_seq_pc);

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_epc <= 32'h0;
    end else if (r_state == S_EXEC && bus.exec_done && w_take_trap) begin
      r_epc <= bus.pc_current;
    end
  end

  assign bus.epc = r_epc;
`else
  logic w_unused_exc;

  assign w_unused_exc = bus.exc;
  assign w_sel_pc     = w_redirect ? (w_tgt & ~32'h3) : w_seq_pc;
  assign bus.epc      = 32'h0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start)     w_state_nxt = S_LOAD;
      S_LOAD:                      w_state_nxt = S_FETCH;
      S_FETCH:  if (bus.imem_ack)  w_state_nxt = S_EXEC;
      S_EXEC:   if (bus.exec_done) w_state_nxt = S_UPDATE;
      S_UPDATE:                    w_state_nxt = bus.halt ? S_HALTED : S_FETCH;
      S_HALTED: if (bus.start)     w_state_nxt = S_FETCH;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // r_pc_next is only loaded on the edges entering LOAD/UPDATE, so it holds elsewhere.
  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      r_state   <= S_IDLE;
      r_pc_next <= 32'h0;
      r_retired <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.start) begin
        r_pc_next <= RESET_VECTOR;
      end else if (r_state == S_EXEC && bus.exec_done) begin
        r_pc_next <= w_sel_pc;
      end
      if (r_state == S_UPDATE) begin
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign bus.imem_req = (r_state == S_FETCH);
  assign bus.pc_write = (r_state == S_LOAD) || (r_state == S_UPDATE);
  assign bus.busy     = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign bus.pc_next  = r_pc_next;
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed table-driven bench for pc_sequencer (either PC_SEQUENCER_TRAP_EN build)
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic rst_n_a;
  int   n_checks;
  int   n_err;
  logic [31:0] exp_ret;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0100),
    .TRAP_VECTOR  (TV),
    .PC_INC       (32'd4)
  ) dut (
    .clk     (clk),
    .rst_n_a (rst_n_a),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic        br;
    logic [31:0] jt;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    string       name;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start         = 1'b0;
    bus.halt          = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.exec_done     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.jump          = 1'b0;
    bus.exc           = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump_target   = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, {31'h0, bus.imem_req}, 32'h0);
    chk({tag, "_pc_write"}, {31'h0, bus.pc_write}, 32'h0);
    chk({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
    chk({tag, "_pc_next"},  bus.pc_next,           32'h0);
    chk({tag, "_epc"},      bus.epc,               32'h0);
    chk({tag, "_retired"},  bus.retired,           32'h0);
  endtask

  initial begin
    int req_cnt;
    n_checks = 0;
    n_err    = 0;

    vt[0] = '{1'b1, 1'b1, 32'h2000, 32'h3000, 1'b0, 32'h0000_0100, 32'h2000, 32'h0, "jump_over_branch"};
    vt[1] = '{1'b0, 1'b1, 32'h0,    32'h3000, 1'b0, 32'h0000_2000, 32'h3000, 32'h0, "branch_taken"};
    vt[2] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 32'hFFFF_FFFC, 32'h0,    32'h0, "seq_wrap"};
    vt[3] = '{1'b0, 1'b1, 32'h0,    32'h0402, 1'b0, 32'h0000_0080,
              TRAP ? TV : 32'h0400, TRAP ? 32'h80 : 32'h0, "branch_misaligned"};
    vt[4] = '{1'b1, 1'b1, 32'h2003, 32'h5000, 1'b0, 32'h0000_0090,
              TRAP ? TV : 32'h2000, TRAP ? 32'h90 : 32'h0, "jump_misaligned"};
    vt[5] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 32'h0000_0040,
              TRAP ? TV : 32'h0044, TRAP ? 32'h40 : 32'h0, "exception"};
    vt[6] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 32'h0000_1234,
              32'h1238, TRAP ? 32'h40 : 32'h0, "seq_plain"};

    clear_inputs();
    bus.pc_current = 32'h0;
    rst_n_a = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst_n_a = 1'b1;
    step();
    chk("idle_busy", {31'h0, bus.busy}, 32'h0);

    // Start: one LOAD cycle writing the reset vector
    bus.start = 1'b1;
    step();
    chk("load_pc_write", {31'h0, bus.pc_write}, 32'h1);
    chk("load_pc_next",  bus.pc_next,           32'h100);
    chk("load_busy",     {31'h0, bus.busy},     32'h1);
    bus.start = 1'b0;
    step();
    chk("fetch_pc_write", {31'h0, bus.pc_write}, 32'h0);
    bus.pc_current = 32'h100;

    // imem_ack in the fourth FETCH cycle -> imem_req high for exactly 4 cycles
    req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.imem_req) req_cnt++;
      if (i == 3) bus.imem_ack = 1'b1;
      step();
    end
    bus.imem_ack = 1'b0;
    chk("imem_req_cycles", req_cnt, 32'd4);
    chk("exec_imem_req", {31'h0, bus.imem_req}, 32'h0);
    step();
    chk("exec_wait_pc_write", {31'h0, bus.pc_write}, 32'h0);
    chk("exec_wait_pc_next",  bus.pc_next,           32'h100);
    bus.exec_done = 1'b1;
    step();
    bus.exec_done = 1'b0;
    chk("update_pc_write", {31'h0, bus.pc_write}, 32'h1);
    chk("update_pc_next",  bus.pc_next,           32'h104);
    step();
    chk("retired_first",   bus.retired,           32'h1);
    chk("after_pc_write",  {31'h0, bus.pc_write}, 32'h0);
    chk("after_pc_next",   bus.pc_next,           32'h104);
    chk("after_imem_req",  {31'h0, bus.imem_req}, 32'h1);
    exp_ret = 32'h1;

    // Table of next-PC selections, each run at minimum latency from FETCH
    for (int i = 0; i < 7; i++) begin
      bus.imem_ack = 1'b1;
      step();
      bus.imem_ack      = 1'b0;
      bus.exec_done     = 1'b1;
      bus.jump          = vt[i].jump;
      bus.branch_taken  = vt[i].br;
      bus.jump_target   = vt[i].jt;
      bus.branch_target = vt[i].bt;
      bus.exc           = vt[i].exc;
      bus.pc_current    = vt[i].pc;
      step();
      clear_inputs();
      chk({vt[i].name, "_pc_write"}, {31'h0, bus.pc_write}, 32'h1);
      chk({vt[i].name, "_pc_next"},  bus.pc_next,           vt[i].exp_pc);
      chk({vt[i].name, "_epc"},      bus.epc,               vt[i].exp_epc);
      step();
      exp_ret = exp_ret + 32'd1;
      chk({vt[i].name, "_retired"},  bus.retired,           exp_ret);
      chk({vt[i].name, "_imem_req"}, {31'h0, bus.imem_req}, 32'h1);
    end

    // halt raised mid-FETCH completes the instruction, then HALTED
    bus.halt = 1'b1;
    step();
    chk("halt_fetch_req",  {31'h0, bus.imem_req}, 32'h1);
    chk("halt_fetch_busy", {31'h0, bus.busy},     32'h1);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack   = 1'b0;
    bus.exec_done  = 1'b1;
    bus.pc_current = 32'h500;
    step();
    bus.exec_done = 1'b0;
    chk("halt_update_pc_next", bus.pc_next, 32'h504);
    step();
    exp_ret = exp_ret + 32'd1;
    chk("halted_busy",     {31'h0, bus.busy},     32'h0);
    chk("halted_imem_req", {31'h0, bus.imem_req}, 32'h0);
    chk("halted_retired",  bus.retired,           exp_ret);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("halted_ignores_ack", {31'h0, bus.busy}, 32'h0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    chk("resume_imem_req", {31'h0, bus.imem_req}, 32'h1);
    chk("resume_pc_write", {31'h0, bus.pc_write}, 32'h0);
    chk("resume_pc_next",  bus.pc_next,           32'h504);

    // Asynchronous reset while waiting in EXEC
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    chk("exec_busy", {31'h0, bus.busy}, 32'h1);
    #2;
    rst_n_a = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    bus.imem_ack = 1'b1;
    rst_n_a = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("idle_ignores_ack_req",  {31'h0, bus.imem_req}, 32'h0);
    chk("idle_ignores_ack_busy", {31'h0, bus.busy},     32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
